// File: rtl/myriadrf_pkg.sv
// Shared MyriadRF types and constants for the RX framer and TX deframer.
package myriadrf_pkg;

  localparam int unsigned DIQ_W    = 12;
  localparam int unsigned SAMPLE_W = 24;

  typedef enum logic [1:0] {
    RXF_IDLE   = 2'd0,
    RXF_WAIT_I = 2'd1,
    RXF_WAIT_Q = 2'd2
  } rxf_state_e;

  // I lands in the upper half unless swapped.
  function automatic logic [SAMPLE_W-1:0] pack_sample(
    input logic [DIQ_W-1:0] i_word,
    input logic [DIQ_W-1:0] q_word,
    input logic             swap
  );
    return swap ? {q_word, i_word} : {i_word, q_word};
  endfunction

endpackage

// File: rtl/myriadrf_sync_fifo.sv
// Registered first-word-fall-through FIFO; the head sample lives in a read register.
module myriadrf_sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_left;
  logic [CW-1:0]    w_count_nxt;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = pop_i & r_valid;
  assign w_push  = push_i & (~w_full | w_pop);

  always_comb begin
    w_count_left = r_count - CW'(w_pop);
    w_count_nxt  = w_count_left + CW'(w_push);
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  // Head register: bypass the write when the pushed word becomes the new head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      if (w_push && (w_count_left == '0)) begin
        r_dout <= wdata_i;
      end else if (w_count_left != '0) begin
        r_dout <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  assign rdata_o = r_dout;
  assign full_o  = w_full;
  assign empty_o = ~r_valid;

endmodule

// File: rtl/myriadrf_rx_framer.sv
// Pairs interleaved LMS6002D DIQ words into 24-bit samples, queues them and
// tracks overflow / framing status.
module myriadrf_rx_framer
  import myriadrf_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned OVF_CW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_en_i,
  input  logic                swap_iq_i,
  input  logic [DIQ_W-1:0]    diq_i,
  input  logic                iqsel_i,
  output logic [SAMPLE_W-1:0] m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                ovf_o,
  output logic [OVF_CW-1:0]   ovf_cnt_o,
  output logic                sync_err_o,
  input  logic                stat_clr_i
);

  rxf_state_e          r_state;
  rxf_state_e          w_state_nxt;
  rxf_state_e          w_state_eff;
  logic [DIQ_W-1:0]    r_i_reg;
  logic                r_ovf;
  logic [OVF_CW-1:0]   r_ovf_cnt;
  logic                r_sync_err;

  logic                w_i_latch;
  logic                w_pair;
  logic                w_sync_evt;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_drop;
  logic [SAMPLE_W-1:0] w_sample;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RXF_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The enabling cycle's word is treated as if already in WAIT_I.
  always_comb begin
    w_state_nxt = r_state;
    w_i_latch   = 1'b0;
    w_pair      = 1'b0;
    w_sync_evt  = 1'b0;
    w_state_eff = (r_state == RXF_IDLE) ? RXF_WAIT_I : r_state;
    if (!rx_en_i) begin
      w_state_nxt = RXF_IDLE;
    end else begin
      case (w_state_eff)
        RXF_WAIT_Q: begin
          if (iqsel_i) begin
            w_i_latch   = 1'b1;
            w_sync_evt  = 1'b1;
            w_state_nxt = RXF_WAIT_Q;
          end else begin
            w_pair      = 1'b1;
            w_state_nxt = RXF_WAIT_I;
          end
        end
        default: begin
          if (iqsel_i) begin
            w_i_latch   = 1'b1;
            w_state_nxt = RXF_WAIT_Q;
          end else begin
            w_sync_evt  = 1'b1;
            w_state_nxt = RXF_WAIT_I;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            r_i_reg <= '0;
    else if (w_i_latch) r_i_reg <= diq_i;
  end

  assign w_sample = pack_sample(r_i_reg, diq_i, swap_iq_i);
  assign w_pop    = ~w_empty & m_ready_i;
  assign w_drop   = w_pair & w_full & ~w_pop;

  myriadrf_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_pair),
    .pop_i   (w_pop),
    .wdata_i (w_sample),
    .rdata_o (m_data_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Clear wins over any same-cycle set or increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr_i) begin
      r_ovf      <= 1'b0;
      r_ovf_cnt  <= '0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + OVF_CW'(1);
      end
      if (w_sync_evt) r_sync_err <= 1'b1;
    end
  end

  assign m_valid_o  = ~w_empty;
  assign ovf_o      = r_ovf;
  assign ovf_cnt_o  = r_ovf_cnt;
  assign sync_err_o = r_sync_err;

endmodule

// File: tb/tb_myriadrf_rx_framer.sv
// Randomized and directed bench for myriadrf_rx_framer against a queue-based reference model.
module tb_myriadrf_rx_framer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_en_i;
  logic        swap_iq_i;
  logic [11:0] diq_i;
  logic        iqsel_i;
  logic [23:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        ovf_o;
  logic [15:0] ovf_cnt_o;
  logic        sync_err_o;
  logic        stat_clr_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [23:0] mq[$];
  bit          m_has_i;
  logic [11:0] m_i;
  bit          m_ovf;
  bit          m_serr;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  myriadrf_rx_framer #(.FIFO_AW(2), .OVF_CW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_en_i    (rx_en_i),
    .swap_iq_i  (swap_iq_i),
    .diq_i      (diq_i),
    .iqsel_i    (iqsel_i),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .ovf_o      (ovf_o),
    .ovf_cnt_o  (ovf_cnt_o),
    .sync_err_o (sync_err_o),
    .stat_clr_i (stat_clr_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the behavioural model, using the inputs currently driven.
  task automatic model_edge();
    bit          pop;
    bit          pair;
    bit          serr_evt;
    bit          drop;
    logic [23:0] s;
    logic [23:0] popped;
    if (rst) begin
      mq.delete();
      m_has_i = 0; m_i = '0; m_ovf = 0; m_serr = 0; m_cnt = 0;
      return;
    end
    pop      = (mq.size() > 0) && m_ready_i;
    pair     = 0;
    serr_evt = 0;
    s        = '0;
    if (!rx_en_i) begin
      m_has_i = 0;
    end else if (iqsel_i) begin
      if (m_has_i) serr_evt = 1;
      m_has_i = 1;
      m_i     = diq_i;
    end else if (m_has_i) begin
      pair    = 1;
      s       = swap_iq_i ? {diq_i, m_i} : {m_i, diq_i};
      m_has_i = 0;
    end else begin
      serr_evt = 1;
    end
    if (pop) popped = mq.pop_front();
    drop = 0;
    if (pair) begin
      if (mq.size() >= DEPTH) drop = 1;
      else mq.push_back(s);
    end
    if (stat_clr_i) begin
      m_ovf = 0; m_cnt = 0; m_serr = 0;
    end else begin
      if (drop) begin
        m_ovf = 1;
        if (m_cnt < 32'hFFFF) m_cnt++;
      end
      if (serr_evt) m_serr = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("valid", 32'(m_valid_o), 32'(mq.size() > 0));
    if (mq.size() > 0) check_eq("data", 32'(m_data_o), 32'(mq[0]));
    check_eq("ovf", 32'(ovf_o), 32'(m_ovf));
    check_eq("ovf_cnt", 32'(ovf_cnt_o), m_cnt);
    check_eq("sync_err", 32'(sync_err_o), 32'(m_serr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic word(input logic en, input logic iq, input logic [11:0] d);
    rx_en_i = en; iqsel_i = iq; diq_i = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) word(1'b0, 1'b0, 12'h000);
  endtask

  task automatic clear_status();
    stat_clr_i = 1'b1;
    word(1'b0, 1'b0, 12'h000);
    stat_clr_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_en_i = 0; swap_iq_i = 0; diq_i = '0; iqsel_i = 0;
    m_ready_i = 0; stat_clr_i = 0;
    tick(); tick();
    check_eq("rst_data", 32'(m_data_o), 32'h0);
    check_eq("rst_valid", 32'(m_valid_o), 32'h0);
    rst = 1'b0;
    tick();

    // Basic pairing at full rate
    m_ready_i = 1;
    for (int p = 0; p < 4; p++) begin
      word(1, 1, 12'h123);
      word(1, 0, 12'h456);
      check_eq("basic_data", 32'(m_data_o), 32'h123456);
      check_eq("basic_valid", 32'(m_valid_o), 32'h1);
    end
    check_eq("basic_serr", 32'(sync_err_o), 32'h0);
    idle(2);

    // Swap
    swap_iq_i = 1;
    word(1, 1, 12'h123);
    word(1, 0, 12'h456);
    check_eq("swap_data", 32'(m_data_o), 32'h456123);
    swap_iq_i = 0;
    idle(2);

    // Overflow: six pairs into a four-deep FIFO
    m_ready_i = 0;
    for (int p = 0; p < 6; p++) begin
      word(1, 1, 12'(12'h100 + p));
      word(1, 0, 12'(12'h200 + p));
    end
    idle(1);
    check_eq("ovf_flag", 32'(ovf_o), 32'h1);
    check_eq("ovf_count", 32'(ovf_cnt_o), 32'h2);
    check_eq("ovf_head", 32'(m_data_o), 32'h100200);
    m_ready_i = 1;
    idle(5);
    clear_status();
    check_eq("clr_ovf", 32'(ovf_o), 32'h0);
    check_eq("clr_cnt", 32'(ovf_cnt_o), 32'h0);

    // Full FIFO with push and pop on the same edge
    m_ready_i = 0;
    for (int p = 0; p < 4; p++) begin
      word(1, 1, 12'(12'h300 + p));
      word(1, 0, 12'(12'h400 + p));
    end
    word(1, 1, 12'h3AA);
    m_ready_i = 1;
    word(1, 0, 12'h4AA);
    check_eq("pp_cnt", 32'(ovf_cnt_o), 32'h0);
    check_eq("pp_ovf", 32'(ovf_o), 32'h0);
    idle(6);

    // I-I-Q: newest I wins
    word(1, 1, 12'h111);
    word(1, 1, 12'h222);
    word(1, 0, 12'h333);
    check_eq("ii_data", 32'(m_data_o), 32'h222333);
    check_eq("ii_serr", 32'(sync_err_o), 32'h1);
    idle(3);
    clear_status();

    // Leading stray Q
    word(1, 0, 12'h777);
    idle(1);
    check_eq("stray_serr", 32'(sync_err_o), 32'h1);
    check_eq("stray_valid", 32'(m_valid_o), 32'h0);
    clear_status();

    // Disable mid-pair, then re-enable with Q first
    word(1, 1, 12'h5A5);
    word(0, 0, 12'h000);
    word(1, 0, 12'h6B6);
    check_eq("dis_valid", 32'(m_valid_o), 32'h0);
    idle(1);
    clear_status();

    // Reset with three queued samples and a partial I
    m_ready_i = 0;
    for (int p = 0; p < 3; p++) begin
      word(1, 1, 12'(12'h700 + p));
      word(1, 0, 12'(12'h800 + p));
    end
    word(1, 0, 12'h999);
    word(1, 1, 12'hABC);
    rst = 1; tick(); rst = 0;
    check_eq("rst_mid_valid", 32'(m_valid_o), 32'h0);
    check_eq("rst_mid_serr", 32'(sync_err_o), 32'h0);
    m_ready_i = 1;
    word(1, 0, 12'hDEF);
    word(1, 1, 12'h0F1);
    word(1, 0, 12'h0F2);
    check_eq("post_rst_data", 32'(m_data_o), 32'h0F10F2);
    idle(2);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 499) == 0);
      stat_clr_i = ($urandom_range(0, 99) == 0);
      swap_iq_i  = $urandom_range(0, 1);
      m_ready_i  = ($urandom_range(0, 3) != 0);
      rx_en_i    = ($urandom_range(0, 15) != 0);
      iqsel_i    = ($urandom_range(0, 9) < 1) ? ~iqsel_i : iqsel_i;
      iqsel_i    = ($urandom_range(0, 1) == 0) ? ~iqsel_i : iqsel_i;
      diq_i      = 12'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
